cache_arbiter: RTL
==================

# cache_arbiter

Shares one data-cache port between the load/store units of `NUM_CORES` cores. Each core's load or store FSM pulses a request. The arbiter latches the request, picks one pending request at a time in round-robin order, and drives the cache port. When the cache completes, it returns a one-cycle grant and the read data to the owning core. The block sits between the per-core load/store units and the shared cache, and is the only master of the cache port.

## Interface
- `NUM_CORES`, 4, number of requesting cores (2..8)
- `ADDR_W`, 12, cache address width
- `DATA_W`, 8, cache data width
- `TIMEOUT`, 255, maximum WAIT cycles before the access is aborted (1..65535)

One clock; reset is asynchronous and active-low. Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous active-low reset
- `req_valid`  in  NUM_CORES  per-core one-cycle request pulse
- `req_we`  in  NUM_CORES  per-core direction: 1 = store, 0 = load
- `req_addr`  in  NUM_CORES*ADDR_W  per-core address; core i occupies bits [i*ADDR_W +: ADDR_W]
- `req_wdata`  in  NUM_CORES*DATA_W  per-core store data, packed the same way
- `gnt`  out  NUM_CORES  one-hot completion pulse to the owning core
- `err`  out  1  qualifies `gnt`: the access timed out
- `rdata`  out  DATA_W  load data; valid only while `gnt` is nonzero
- `cache_valid`  out  1  one-cycle access strobe to the cache
- `cache_we`  out  1  access direction
- `cache_addr`  out  ADDR_W  access address
- `cache_wdata`  out  DATA_W  store data
- `cache_ready`  in  1  cache completion pulse
- `cache_rdata`  in  DATA_W  cache read data; valid while `cache_ready` is high
- `busy`  out  1  1 in any state other than IDLE
- `owner`  out  clog2(NUM_CORES)  index of the core currently being served

## Operation
- **Request capture.** Per core, a `pending` bit plus latched `we`, `addr` and `wdata`.
  - `req_valid[i]` at a rising edge sets `pending[i]` and latches that core's fields.
  - If `pending[i]` is already set, the new pulse is dropped. Latched fields are unchanged.
- **FSM states:** IDLE, ISSUE, WAIT, DONE.
- **IDLE.** If any `pending` bit is set:
  - The winner is the first pending core searching upward from `last_owner+1`, modulo `NUM_CORES`.
  - The winner is registered into `owner` and the FSM moves to ISSUE.
  - With no pending bit set, the FSM stays in IDLE.
- **ISSUE.** `cache_valid`=1 for exactly this cycle. `cache_we`, `cache_addr` and `cache_wdata` come from the owner's latched fields. The FSM moves to WAIT and the timeout counter is cleared.
- **WAIT.** The cache fields are held stable and `cache_valid`=0.
  - `cache_ready`=1: `cache_rdata` is captured into `rdata`; the FSM moves to DONE with `err`=0.
  - Counter reaching `TIMEOUT`: `rdata`=0; the FSM moves to DONE with `err`=1.
  - Otherwise the counter increments.
- **DONE.**
  - `gnt[owner]`=1 for one cycle; `err` is driven as decided in WAIT.
  - `pending[owner]` is cleared and `last_owner` <= `owner`. The FSM moves to IDLE.
- **Store data.** For a store, `rdata` holds whatever the cache returned; cores ignore it.
- **cache_ready outside WAIT** is ignored.
- **Width rules.**
  - The timeout counter is 16 bits and saturates; it never wraps.
  - `owner` and `last_owner` are clog2(NUM_CORES) bits wide. The round-robin index wraps from `NUM_CORES-1` to 0.

## Timing
- **Reset values** while `rst`=0, immediately and asynchronously:
  - All outputs 0.
  - FSM in IDLE, all `pending` bits 0, counter 0.
  - `last_owner`=NUM_CORES-1, so core 0 has first priority.
- **Reset mid-operation.** Asserting `rst` in any state aborts the access. No `gnt` is issued and all pending requests are lost.
- **Minimum latency**, with `req_valid` at cycle t on an idle arbiter:
  - Pending visible at t+1.
  - ISSUE (`cache_valid`) at t+2.
  - WAIT at t+3; `cache_ready` in that cycle gives `gnt` at t+4.
- **Per-access cost.** One access occupies 4 cycles minimum (IDLE, ISSUE, WAIT, DONE). Back-to-back throughput is one access per 4 cycles.
- **Simultaneous request and grant.** If `req_valid[owner]` arrives in the DONE cycle, set wins over clear: the new request is captured with its new fields and becomes pending.
- **Simultaneous requests.** Requests from several cores in the same cycle are all captured and are served in round-robin order.
- **Timeout boundary.** `cache_ready` in the same cycle the counter reaches `TIMEOUT` counts as success (`err`=0).

## Test plan
- **Single load.** Core 2 requests a load of 0x0A5; the cache answers 0x3C one cycle into WAIT -> `cache_addr`=0x0A5, `cache_we`=0, `cache_valid` 1 cycle; `gnt`=4'b0100 at t+4 with `rdata`=0x3C, `err`=0.
- **Simultaneous requests.** All four cores request at once and each access completes immediately -> grants in order core 0,1,2,3, spaced 4 cycles apart; `cache_addr`/`cache_wdata` track each core's latched fields.
- **Round-robin fairness.** Core 1 and core 3 request continuously, re-requesting on their DONE cycle -> grants alternate 1,3,1,3 and neither core is starved.
- **Timeout.** With `TIMEOUT`=4, core 0 stores 0x55 to 0xFFF and `cache_ready` is never asserted -> `gnt`=4'b0001 with `err`=1 and `rdata`=0, exactly 5 WAIT cycles after ISSUE; a subsequent request is served normally.
- **Reset mid-operation.** Pulse `rst` low during WAIT with two requests pending -> all outputs go to 0 at once, no `gnt` is issued, and after release core 0 is served first.
- **Duplicate request.** Core 1 issues a second `req_valid` with a different address while already pending -> the second pulse is dropped; the single `gnt` carries the first address's access.

Source files
------------

// File: rtl/cache_arbiter.sv
// cache_arbiter: round-robin sharing of one data-cache port between the
// load/store units of NUM_CORES cores; one access in flight at a time.
`timescale 1ns/1ps

module cache_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CORES-1:0]           req_valid,
    input  logic [NUM_CORES-1:0]           req_we,
    input  logic [NUM_CORES*ADDR_W-1:0]    req_addr,
    input  logic [NUM_CORES*DATA_W-1:0]    req_wdata,
    output logic [NUM_CORES-1:0]           gnt,
    output logic                           err,
    output logic [DATA_W-1:0]              rdata,
    output logic                           cache_valid,
    output logic                           cache_we,
    output logic [ADDR_W-1:0]              cache_addr,
    output logic [DATA_W-1:0]              cache_wdata,
    input  logic                           cache_ready,
    input  logic [DATA_W-1:0]              cache_rdata,
    output logic                           busy,
    output logic [$clog2(NUM_CORES)-1:0]   owner
);

    localparam int OW = $clog2(NUM_CORES);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [15:0]   TO_LIM   = 16'(TIMEOUT);
    localparam logic [OW-1:0] LAST_IDX = OW'(NUM_CORES - 1);

    logic [1:0]                          state_q, state_d;
    logic [NUM_CORES-1:0]                pend_q, pend_d;
    logic [NUM_CORES-1:0]                we_q;
    logic [NUM_CORES-1:0][ADDR_W-1:0]    addr_q;
    logic [NUM_CORES-1:0][DATA_W-1:0]    wdata_q;
    logic [OW-1:0]                       owner_q, owner_d;
    logic [OW-1:0]                       last_q, last_d;
    logic [15:0]                         cnt_q, cnt_d;
    logic [DATA_W-1:0]                   rdata_q, rdata_d;
    logic                                err_q, err_d;

    logic [NUM_CORES-1:0]                take;
    logic                                found;
    logic [OW-1:0]                       win;
    logic [OW-1:0]                       cand;
    logic                                in_access;

    // Round-robin search starting just above the previous owner.
    always_comb begin
        found = 1'b0;
        win   = last_q;
        cand  = last_q;
        for (int k = 0; k < NUM_CORES; k++) begin
            cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
            if (!found && pend_q[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // A new pulse is taken when the slot is free or being released this
    // cycle, so a re-request on the grant cycle is never lost.
    always_comb begin
        take   = '0;
        pend_d = pend_q;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (state_q == S_DONE && owner_q == OW'(i)) begin
                pend_d[i] = 1'b0;
            end
            if (req_valid[i] && (!pend_q[i] || !pend_d[i])) begin
                take[i]   = 1'b1;
                pend_d[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    owner_d = win;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cache_ready) begin
                    rdata_d = cache_rdata;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (cnt_q == TO_LIM) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DONE: begin
                last_d  = owner_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pend_q  <= '0;
            owner_q <= '0;
            last_q  <= LAST_IDX;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (take[i]) begin
                    we_q[i]    <= req_we[i];
                    addr_q[i]  <= req_addr[i*ADDR_W +: ADDR_W];
                    wdata_q[i] <= req_wdata[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign in_access   = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign busy        = (state_q != S_IDLE);
    assign owner       = owner_q;
    assign cache_valid = (state_q == S_ISSUE);
    assign cache_we    = in_access & we_q[owner_q];
    assign cache_addr  = in_access ? addr_q[owner_q] : '0;
    assign cache_wdata = in_access ? wdata_q[owner_q] : '0;
    assign err         = (state_q == S_DONE) & err_q;
    assign rdata       = (state_q == S_DONE) ? rdata_q : '0;

    always_comb begin
        gnt = '0;
        if (state_q == S_DONE) begin
            gnt[owner_q] = 1'b1;
        end
    end

endmodule
